// File: rtl/axi4_full_master_burst_rw.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axi4_full_master_burst_rw
// Brief    : AXI4 full master with independent read and write engines. Each
//            engine splits a run of beats into INCR bursts of at most
//            C_M_AXI_MAX_BURST_LEN beats and bridges it to a valid/ready port.
//            Optional macro STREAMIF_4K_BOUNDARY_EN also splits bursts at
//            4 KB page boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_full_master_burst_rw #(
  parameter int                          C_M_AXI_ADDR_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
  parameter int                          C_M_AXI_MAX_BURST_LEN      = 16,
  parameter int                          C_M_AXI_ID_WIDTH           = 1,
  parameter int                          C_M_AXI_DATA_WIDTH         = 32,
  parameter int                          C_LEN_WIDTH                = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // write user port
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_address,
  input  logic [C_LEN_WIDTH-1:0]          wr_beats,
  input  logic                            wr_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                            wr_data_valid,
  output logic                            wr_data_ready,
  output logic                            wr_busy,
  output logic                            wr_done,
  // read user port
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   rd_address,
  input  logic [C_LEN_WIDTH-1:0]          rd_beats,
  input  logic                            rd_start,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_data_valid,
  output logic                            rd_data_last,
  input  logic                            rd_data_ready,
  output logic                            rd_busy,
  output logic                            rd_done,
  // status
  output logic                            error,
  input  logic                            error_clear,
  // AW channel
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // W channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // B channel
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AR channel
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // R channel
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int SIZE_LG = $clog2(C_M_AXI_DATA_WIDTH/8);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~(C_M_AXI_ADDR_WIDTH'((1 << SIZE_LG) - 1));

  // Beats for the next burst: limited by remaining count, MAX and (optionally) page end.
`ifdef STREAMIF_4K_BOUNDARY_EN
  function automatic logic [8:0] burst_of(input logic [11:0] page_off,
                                          input logic [C_LEN_WIDTH-1:0] rem);
    logic [31:0] b, r, bnd;
    r = 32'(rem);
    b = 32'(C_M_AXI_MAX_BURST_LEN);
    if (r < b) b = r;
    bnd = (32'd4096 - {20'd0, page_off}) >> SIZE_LG;
    if (bnd < b) b = bnd;
    return b[8:0];
  endfunction
`else
  function automatic logic [8:0] burst_of(input logic [11:0] unused_page_off,
                                          input logic [C_LEN_WIDTH-1:0] rem);
    logic [31:0] b, r;
    r = 32'(rem);
    b = 32'(C_M_AXI_MAX_BURST_LEN);
    if (r < b) b = r;
    return b[8:0];
  endfunction
`endif

  function automatic logic [7:0] len_of(input logic [8:0] beats);
    logic [8:0] l;
    l = beats - 9'd1;
    return l[7:0];
  endfunction

  // Inputs that carry no information for this master.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_BID, M_AXI_BRESP[0], M_AXI_RID, M_AXI_RRESP[0]};

  typedef enum logic [1:0] {W_IDLE, W_AADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_AADDR, R_DATA}         rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [C_LEN_WIDTH-1:0]        wr_rem, rd_rem;
  logic [7:0]                    wr_len, rd_len, wr_cnt, rd_cnt;
  logic [8:0]                    wr_burst, rd_burst;
  logic                          wr_go, rd_go, w_hs, b_hs, r_hs;
  logic                          wr_last_beat, rd_exp_last, err_evt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_aligned, rd_aligned;

  assign wr_go        = wr_start && (wr_beats != '0);
  assign rd_go        = rd_start && (rd_beats != '0);
  assign wr_aligned   = wr_address & ALIGN_MASK;
  assign rd_aligned   = rd_address & ALIGN_MASK;
  assign wr_burst     = {1'b0, wr_len} + 9'd1;
  assign rd_burst     = {1'b0, rd_len} + 9'd1;
  assign wr_last_beat = (wr_cnt == wr_len);
  assign rd_exp_last  = (rd_cnt == rd_len);
  assign w_hs         = (wr_state == W_DATA) && wr_data_valid && M_AXI_WREADY;
  assign b_hs         = (wr_state == W_RESP) && M_AXI_BVALID;
  assign r_hs         = (rd_state == R_DATA) && M_AXI_RVALID && rd_data_ready;

  // Fixed AXI attributes and address/length presentation.
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_TARGET_SLAVE_BASE_ADDR + wr_addr;
  assign M_AXI_AWLEN   = wr_len;
  assign M_AXI_AWSIZE  = 3'(SIZE_LG);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0010;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_WDATA   = wr_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = C_M_TARGET_SLAVE_BASE_ADDR + rd_addr;
  assign M_AXI_ARLEN   = rd_len;
  assign M_AXI_ARSIZE  = 3'(SIZE_LG);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0010;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign rd_data       = M_AXI_RDATA;
  assign wr_busy       = (wr_state != W_IDLE);
  assign rd_busy       = (rd_state != R_IDLE);

  // Write engine state register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) wr_state <= W_IDLE;
    else                wr_state <= wr_state_nxt;
  end

  // Write engine next state and channel controls.
  always_comb begin
    wr_state_nxt  = wr_state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    wr_data_ready = 1'b0;
    case (wr_state)
      W_IDLE:  if (wr_go) wr_state_nxt = W_AADDR;
      W_AADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        M_AXI_WVALID  = wr_data_valid;
        M_AXI_WLAST   = wr_last_beat;
        wr_data_ready = M_AXI_WREADY;
        if (w_hs && wr_last_beat) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) wr_state_nxt = (wr_rem == '0) ? W_IDLE : W_AADDR;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write address/count bookkeeping; address and remaining advance at AW handshake.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_addr <= '0;
      wr_rem  <= '0;
      wr_len  <= '0;
      wr_cnt  <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (wr_state)
        W_IDLE: if (wr_go) begin
          wr_addr <= wr_aligned;
          wr_rem  <= wr_beats;
          wr_len  <= len_of(burst_of(wr_aligned[11:0], wr_beats));
          wr_cnt  <= '0;
        end
        W_AADDR: if (M_AXI_AWREADY) begin
          wr_addr <= wr_addr + (C_M_AXI_ADDR_WIDTH'(wr_burst) << SIZE_LG);
          wr_rem  <= wr_rem - C_LEN_WIDTH'(wr_burst);
          wr_cnt  <= '0;
        end
        W_DATA: if (w_hs) wr_cnt <= wr_last_beat ? 8'd0 : wr_cnt + 8'd1;
        W_RESP: if (M_AXI_BVALID) begin
          if (wr_rem == '0) wr_done <= 1'b1;
          else              wr_len  <= len_of(burst_of(wr_addr[11:0], wr_rem));
        end
        default: ;
      endcase
    end
  end

  // Read engine state register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) rd_state <= R_IDLE;
    else                rd_state <= rd_state_nxt;
  end

  // Read engine next state and channel controls.
  always_comb begin
    rd_state_nxt  = rd_state;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rd_data_valid = 1'b0;
    rd_data_last  = 1'b0;
    case (rd_state)
      R_IDLE:  if (rd_go) rd_state_nxt = R_AADDR;
      R_AADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        M_AXI_RREADY  = rd_data_ready;
        rd_data_valid = M_AXI_RVALID;
        rd_data_last  = M_AXI_RVALID && rd_exp_last && (rd_rem == '0);
        if (r_hs && M_AXI_RLAST) rd_state_nxt = (rd_rem == '0) ? R_IDLE : R_AADDR;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read address/count bookkeeping; mirrors the write side without a response phase.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rd_addr <= '0;
      rd_rem  <= '0;
      rd_len  <= '0;
      rd_cnt  <= '0;
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (rd_state)
        R_IDLE: if (rd_go) begin
          rd_addr <= rd_aligned;
          rd_rem  <= rd_beats;
          rd_len  <= len_of(burst_of(rd_aligned[11:0], rd_beats));
          rd_cnt  <= '0;
        end
        R_AADDR: if (M_AXI_ARREADY) begin
          rd_addr <= rd_addr + (C_M_AXI_ADDR_WIDTH'(rd_burst) << SIZE_LG);
          rd_rem  <= rd_rem - C_LEN_WIDTH'(rd_burst);
          rd_cnt  <= '0;
        end
        R_DATA: if (r_hs) begin
          rd_cnt <= M_AXI_RLAST ? 8'd0 : rd_cnt + 8'd1;
          if (M_AXI_RLAST) begin
            if (rd_rem == '0) rd_done <= 1'b1;
            else              rd_len  <= len_of(burst_of(rd_addr[11:0], rd_rem));
          end
        end
        default: ;
      endcase
    end
  end

  assign err_evt = (b_hs && M_AXI_BRESP[1]) ||
                   (r_hs && (M_AXI_RRESP[1] || (M_AXI_RLAST != rd_exp_last)));

  // Sticky error flag; a new error event takes priority over a clear.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)   error <= 1'b0;
    else if (err_evt)     error <= 1'b1;
    else if (error_clear) error <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_full_master_burst_rw.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi4_full_master_burst_rw
// Brief    : Directed bench for axi4_full_master_burst_rw with a simple AXI
//            slave model, data source and read sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_full_master_burst_rw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] wr_address = '0, rd_address = '0;
  logic [15:0] wr_beats = '0, rd_beats = '0;
  logic        wr_start = 1'b0, rd_start = 1'b0, error_clear = 1'b0;
  logic [31:0] wr_data;
  logic        wr_data_valid, wr_data_ready, wr_busy, wr_done;
  logic [31:0] rd_data;
  logic        rd_data_valid, rd_data_last, rd_data_ready, rd_busy, rd_done, error;
  logic [0:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  awcache, arcache, awqos, arqos, wstrb;

  axi4_full_master_burst_rw #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_TARGET_SLAVE_BASE_ADDR(32'h0),
    .C_M_AXI_MAX_BURST_LEN(16), .C_M_AXI_ID_WIDTH(1),
    .C_M_AXI_DATA_WIDTH(32), .C_LEN_WIDTH(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .wr_address(wr_address), .wr_beats(wr_beats), .wr_start(wr_start),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_busy(wr_busy), .wr_done(wr_done),
    .rd_address(rd_address), .rd_beats(rd_beats), .rd_start(rd_start),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last),
    .rd_data_ready(rd_data_ready), .rd_busy(rd_busy), .rd_done(rd_done),
    .error(error), .error_clear(error_clear),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BID(1'b0), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(1'b0), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bench controls
  bit rnd = 1'b0;
  bit r_err = 1'b0;
  int bad_b_at = -1;
  int wsrc_limit = 0;

  function automatic bit coin();
    return rnd ? bit'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Logs
  logic [31:0] aw_addr_q[$], ar_addr_q[$], wdata_q[$], rd_q[$];
  logic [7:0]  aw_len_q[$], ar_len_q[$];
  bit          wlast_q[$], rdlast_q[$];
  int b_cnt = 0, aw_stab_err = 0, ar_stab_err = 0;
  int wr_done_cnt = 0, rd_done_cnt = 0, wsrc_idx = 0;
  logic        aw_hold, ar_hold;
  logic [31:0] aw_pa, ar_pa;
  logic [7:0]  aw_pl, ar_pl;

  // Slave: AW, W and B channels
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      aw_hold <= 1'b0; aw_pa <= '0; aw_pl <= '0;
    end else begin
      awready <= coin();
      wready  <= coin();
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
      end
      if (aw_hold && (!awvalid || awaddr != aw_pa || awlen != aw_pl)) aw_stab_err <= aw_stab_err + 1;
      aw_hold <= awvalid && !awready;
      aw_pa   <= awaddr;
      aw_pl   <= awlen;
      if (wvalid && wready) begin
        wdata_q.push_back(wdata);
        wlast_q.push_back(wlast);
        if (wlast) begin
          bvalid <= 1'b1;
          bresp  <= (b_cnt + 1 == bad_b_at) ? 2'b10 : 2'b00;
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_cnt  <= b_cnt + 1;
      end
    end
  end

  // Slave: AR and R channels; read data is a function of the beat address
  logic        r_act;
  logic [31:0] r_addr;
  logic [7:0]  r_left;
  assign rdata = r_addr ^ 32'h5A5A_0000;
  assign rlast = (r_left == 8'd0);
  assign rresp = (r_err && r_left == 8'd0) ? 2'b10 : 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0; rvalid <= 1'b0; r_act <= 1'b0; r_addr <= '0; r_left <= '0;
      ar_hold <= 1'b0; ar_pa <= '0; ar_pl <= '0;
    end else begin
      arready <= coin();
      if (ar_hold && (!arvalid || araddr != ar_pa || arlen != ar_pl)) ar_stab_err <= ar_stab_err + 1;
      ar_hold <= arvalid && !arready;
      ar_pa   <= araddr;
      ar_pl   <= arlen;
      if (!r_act) begin
        rvalid <= 1'b0;
        if (arvalid && arready) begin
          r_act <= 1'b1; r_addr <= araddr; r_left <= arlen;
          ar_addr_q.push_back(araddr);
          ar_len_q.push_back(arlen);
        end
      end else if (rvalid && rready) begin
        if (r_left == 8'd0) begin
          r_act <= 1'b0; rvalid <= 1'b0;
        end else begin
          r_addr <= r_addr + 32'd4; r_left <= r_left - 8'd1; rvalid <= coin();
        end
      end else if (!rvalid) begin
        rvalid <= coin();
      end
    end
  end

  // Write data source, read sink and done-pulse monitors
  always @(posedge clk) if (wr_data_valid && wr_data_ready) wsrc_idx <= wsrc_idx + 1;
  always @(negedge clk) begin
    wr_data       = 32'hD000_0000 + wsrc_idx;
    wr_data_valid = (wsrc_idx < wsrc_limit) && coin();
    rd_data_ready = coin();
  end
  always @(posedge clk) begin
    if (rd_data_valid && rd_data_ready) begin
      rd_q.push_back(rd_data);
      rdlast_q.push_back(rd_data_last);
    end
    if (wr_done) wr_done_cnt <= wr_done_cnt + 1;
    if (rd_done) rd_done_cnt <= rd_done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_wr(input logic [31:0] a, input logic [15:0] n);
    wr_address = a; wr_beats = n; wr_start = 1'b1;
    wsrc_limit = wsrc_idx + int'(n);
    @(negedge clk);
    wr_start = 1'b0;
  endtask

  task automatic start_rd(input logic [31:0] a, input logic [15:0] n);
    rd_address = a; rd_beats = n; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while ((wr_busy || rd_busy) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle_timeout"}, 64'(wr_busy || rd_busy), 64'd0);
    tick(2);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, d0, s0, r0, q0, e0, k;
    logic [31:0] exp_a[3];
    logic [7:0]  exp_l[3];

    // Reset values
    tick(3);
    check("rst_awvalid", 64'(awvalid), 0);
    check("rst_wvalid", 64'(wvalid), 0);
    check("rst_wlast", 64'(wlast), 0);
    check("rst_bready", 64'(bready), 0);
    check("rst_arvalid", 64'(arvalid), 0);
    check("rst_rready", 64'(rready), 0);
    check("rst_wr_data_ready", 64'(wr_data_ready), 0);
    check("rst_busy", 64'({wr_busy, rd_busy}), 0);
    check("rst_done", 64'({wr_done, rd_done}), 0);
    check("rst_error", 64'(error), 0);
    check("rst_rd_data_valid", 64'(rd_data_valid), 0);
    check("rst_awaddr", 64'(awaddr), 0);
    check("rst_awlen", 64'(awlen), 0);
    check("rst_araddr", 64'(araddr), 0);
    check("rst_arlen", 64'(arlen), 0);
    rst_n = 1'b1;
    tick(2);

    // 40-beat write at 0x100
    a0 = aw_addr_q.size(); w0 = wdata_q.size(); d0 = wr_done_cnt; s0 = wsrc_idx;
    start_wr(32'h100, 16'd40);
    check("t1_awvalid_next", 64'(awvalid), 1);
    check("t1_busy", 64'(wr_busy), 1);
    check("t1_awsize", 64'(awsize), 2);
    check("t1_awburst", 64'(awburst), 1);
    check("t1_awcache", 64'(awcache), 2);
    check("t1_wstrb", 64'(wstrb), 4'hF);
    wait_idle("t1", 400);
    exp_a = '{32'h100, 32'h140, 32'h180};
    exp_l = '{8'd15, 8'd15, 8'd7};
    check("t1_aw_count", 64'(aw_addr_q.size() - a0), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_awaddr%0d", i), 64'(aw_addr_q[a0+i]), 64'(exp_a[i]));
      check($sformatf("t1_awlen%0d", i), 64'(aw_len_q[a0+i]), 64'(exp_l[i]));
    end
    check("t1_w_count", 64'(wdata_q.size() - w0), 40);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("t1_wdata%0d", i), 64'(wdata_q[w0+i]), 64'(32'hD000_0000 + s0 + i));
      check($sformatf("t1_wlast%0d", i), 64'(wlast_q[w0+i]), 64'(i == 15 || i == 31 || i == 39));
    end
    check("t1_done_pulses", 64'(wr_done_cnt - d0), 1);

    // 8-beat read at 0xFF8
    a0 = ar_addr_q.size(); q0 = rd_q.size(); d0 = rd_done_cnt;
    start_rd(32'hFF8, 16'd8);
    check("t2_arvalid_next", 64'(arvalid), 1);
    wait_idle("t2", 400);
`ifdef STREAMIF_4K_BOUNDARY_EN
    check("t2_ar_count", 64'(ar_addr_q.size() - a0), 2);
    check("t2_araddr0", 64'(ar_addr_q[a0]), 32'hFF8);
    check("t2_arlen0", 64'(ar_len_q[a0]), 1);
    check("t2_araddr1", 64'(ar_addr_q[a0+1]), 32'h1000);
    check("t2_arlen1", 64'(ar_len_q[a0+1]), 5);
`else
    check("t2_ar_count", 64'(ar_addr_q.size() - a0), 1);
    check("t2_araddr0", 64'(ar_addr_q[a0]), 32'hFF8);
    check("t2_arlen0", 64'(ar_len_q[a0]), 7);
`endif
    check("t2_r_count", 64'(rd_q.size() - q0), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_rdata%0d", i), 64'(rd_q[q0+i]), 64'((32'hFF8 + 4*i) ^ 32'h5A5A_0000));
      check($sformatf("t2_rlast%0d", i), 64'(rdlast_q[q0+i]), 64'(i == 7));
    end
    check("t2_done_pulses", 64'(rd_done_cnt - d0), 1);
    check("t2_error", 64'(error), 0);

    // Concurrent 100-beat write and read with random handshakes
    a0 = aw_addr_q.size(); w0 = wdata_q.size(); s0 = wsrc_idx;
    r0 = ar_addr_q.size(); q0 = rd_q.size();
    d0 = wr_done_cnt; e0 = rd_done_cnt;
    rnd = 1'b1;
    start_wr(32'h0, 16'd100);
    start_rd(32'h2000, 16'd100);
    wait_idle("t3", 4000);
    rnd = 1'b0;
    check("t3_aw_count", 64'(aw_addr_q.size() - a0), 7);
    check("t3_aw_last_addr", 64'(aw_addr_q[a0+6]), 32'h180);
    check("t3_aw_last_len", 64'(aw_len_q[a0+6]), 3);
    check("t3_ar_count", 64'(ar_addr_q.size() - r0), 7);
    check("t3_ar_last_addr", 64'(ar_addr_q[r0+6]), 32'h2180);
    check("t3_ar_last_len", 64'(ar_len_q[r0+6]), 3);
    check("t3_w_count", 64'(wdata_q.size() - w0), 100);
    check("t3_r_count", 64'(rd_q.size() - q0), 100);
    for (int i = 0; i < 100; i++) begin
      check($sformatf("t3_wdata%0d", i), 64'(wdata_q[w0+i]), 64'(32'hD000_0000 + s0 + i));
      check($sformatf("t3_rdata%0d", i), 64'(rd_q[q0+i]), 64'((32'h2000 + 4*i) ^ 32'h5A5A_0000));
    end
    check("t3_rlast_final", 64'(rdlast_q[q0+99]), 1);
    check("t3_aw_stable", 64'(aw_stab_err), 0);
    check("t3_ar_stable", 64'(ar_stab_err), 0);
    check("t3_done", 64'({wr_done_cnt - d0, rd_done_cnt - e0}), 64'({32'd1, 32'd1}));
    check("t3_error", 64'(error), 0);

    // BRESP error on burst 2 of 3
    a0 = aw_addr_q.size(); d0 = wr_done_cnt;
    bad_b_at = b_cnt + 2;
    start_wr(32'h300, 16'd40);
    wait_idle("t4", 400);
    bad_b_at = -1;
    check("t4_error_set", 64'(error), 1);
    check("t4_aw_count", 64'(aw_addr_q.size() - a0), 3);
    check("t4_done_pulses", 64'(wr_done_cnt - d0), 1);
    error_clear = 1'b1;
    tick(1);
    error_clear = 1'b0;
    check("t4_error_cleared", 64'(error), 0);
    // Clear held while an RRESP error arrives on the final read beat
    error_clear = 1'b1; r_err = 1'b1;
    start_rd(32'h400, 16'd4);
    k = 0;
    while (!rd_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t4_rd_done_seen", 64'(rd_done), 1);
    check("t4_error_wins", 64'(error), 1);
    error_clear = 1'b0; r_err = 1'b0;
    tick(1);
    check("t4_error_sticky", 64'(error), 1);
    error_clear = 1'b1;
    tick(1);
    error_clear = 1'b0;
    check("t4_error_cleared2", 64'(error), 0);

    // Zero-beat write and a start while the reader is busy
    tick(2);
    a0 = aw_addr_q.size(); d0 = wr_done_cnt;
    start_wr(32'h800, 16'd0);
    check("t5_zero_awvalid", 64'(awvalid), 0);
    check("t5_zero_busy", 64'(wr_busy), 0);
    tick(5);
    check("t5_zero_no_aw", 64'(aw_addr_q.size() - a0), 0);
    check("t5_zero_no_done", 64'(wr_done_cnt - d0), 0);
    r0 = ar_addr_q.size(); q0 = rd_q.size(); e0 = rd_done_cnt;
    start_rd(32'h500, 16'd8);
    tick(1);
    check("t5_rd_busy", 64'(rd_busy), 1);
    start_rd(32'h900, 16'd3);
    wait_idle("t5", 400);
    check("t5_ar_count", 64'(ar_addr_q.size() - r0), 1);
    check("t5_araddr", 64'(ar_addr_q[r0]), 32'h500);
    check("t5_arlen", 64'(ar_len_q[r0]), 7);
    check("t5_r_count", 64'(rd_q.size() - q0), 8);
    check("t5_done_pulses", 64'(rd_done_cnt - e0), 1);

    // Reset during write data phase, then a clean 4-beat write
    start_wr(32'h600, 16'd40);
    k = 0;
    while (!wvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tick(3);
    check("t6_in_data", 64'(wvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_wvalid", 64'(wvalid), 0);
    check("t6_rst_awvalid", 64'(awvalid), 0);
    check("t6_rst_busy", 64'(wr_busy), 0);
    check("t6_rst_wlast", 64'(wlast), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    a0 = aw_addr_q.size(); w0 = wdata_q.size(); d0 = wr_done_cnt; s0 = wsrc_idx;
    start_wr(32'h700, 16'd4);
    wait_idle("t6", 200);
    check("t6_aw_count", 64'(aw_addr_q.size() - a0), 1);
    check("t6_awaddr", 64'(aw_addr_q[a0]), 32'h700);
    check("t6_awlen", 64'(aw_len_q[a0]), 3);
    check("t6_w_count", 64'(wdata_q.size() - w0), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_wdata%0d", i), 64'(wdata_q[w0+i]), 64'(32'hD000_0000 + s0 + i));
    check("t6_wlast", 64'(wlast_q[w0+3]), 1);
    check("t6_done_pulses", 64'(wr_done_cnt - d0), 1);
    check("t6_error", 64'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
